mul_job_sequencer: RTL and testbench
====================================

MUL_JOB_SEQUENCER -- requirements
Module: mul_job_sequencer

Interface
REQ-001 SHALL have parameter W, default 16, meaning operand width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning operand-pair queue entries (power of 2, >=2).
REQ-003 SHALL have parameter TMO, default 2**W+8, meaning watchdog limit in cycles for mul_done.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid/in_ready  input/output  1/1  operand-pair handshake; transfer when both high.
REQ-007 in_a, in_b  input  W  multiplicand, multiplier.
REQ-008 mul_rst  output  1  reset pulse to multiplier controller/datapath.
REQ-009 mul_start  output  1  start to multiplier controller.
REQ-010 mul_data  output  W  shared operand bus into multiplier datapath.
REQ-011 mul_done  input  1  multiplier completion, level, sticky until mul_rst.
REQ-012 mul_product  input  W  product register of multiplier datapath.
REQ-013 out_valid/out_ready  output/input  1/1  result handshake.
REQ-014 out_product, out_err  output  W/1  result; out_err=1 means watchdog abort.

Function
REQ-015 Input side SHALL be a DEPTH-entry FIFO of {a,b}; in_ready = not full; push and pop in the same cycle when full SHALL be refused on push (in_ready low).
REQ-016 FSM states SHALL be IDLE, MRST, START, LDA, LDB, RUN, OUT.
REQ-017 IDLE -> MRST when FIFO non-empty; otherwise stay.
REQ-018 MRST: mul_rst=1 for exactly one cycle; -> START.
REQ-019 START: mul_start=1, mul_data=head.a; -> LDA.
REQ-020 LDA: mul_data=head.a (multiplier loads A this cycle); -> LDB.
REQ-021 LDB: mul_data=head.b; FIFO pop at end of cycle; -> RUN.
REQ-022 RUN: mul_data=0; counter increments; mul_done=1 -> capture mul_product into out_product, out_err=0, -> OUT; counter reaching TMO first -> out_product=0, out_err=1, -> OUT.
REQ-023 OUT: out_valid=1, out_product/out_err stable; out_ready=1 -> IDLE (or MRST directly if FIFO non-empty).
REQ-024 mul_start, mul_rst SHALL be single-cycle pulses; never high outside START/MRST.
REQ-025 Minimum issue-to-result latency SHALL be 5 cycles plus multiplier run time; jobs complete strictly in input order.
REQ-026 out_product SHALL be the low W bits of mul_product; no width growth.

Reset
REQ-027 On rst: state=IDLE, FIFO empty, in_ready=1 next cycle, mul_rst=1 (held during reset), mul_start=0, mul_data=0, out_valid=0, out_product=0, out_err=0, counter=0.
REQ-028 rst mid-job SHALL discard the in-flight job and all queued pairs; no partial result emitted.

Configuration
REQ-029 Macro MUL_SEQ_ZERO_BYPASS_EN: when defined, a head pair with a==0 or b==0 SHALL skip MRST..RUN, pop, and go IDLE -> OUT with out_product=0, out_err=0 (one cycle after IDLE); when undefined, zero operands SHALL go through the multiplier like any other pair.

Structure
REQ-030 Shared package SHALL hold the FSM state enum and the default W/DEPTH constants.
REQ-031 FIFO SHALL be a separate sub-module mul_pair_fifo (width 2*W, depth DEPTH, full/empty flags); the FSM stays in mul_job_sequencer.

Verification
REQ-032 Single job a=5, b=3; model returns mul_done 4 cycles after LDB with product 15 -> out_valid with out_product=15, out_err=0; mul_start seen once, mul_data=5,5,3 in START/LDA/LDB.
REQ-033 Push 5 pairs back-to-back with out_ready=0 -> in_ready low after 4 accepted plus one popped in-flight; release out_ready -> 5 results in order.
REQ-034 Model never asserts mul_done, TMO=20 -> out_valid after 20 RUN cycles, out_product=0, out_err=1; next job proceeds normally.
REQ-035 rst asserted in RUN with 2 pairs queued -> out_valid never asserted for them; in_ready=1 after reset; new job a=2, b=7 -> 14.
REQ-036 a=0, b=9: with MUL_SEQ_ZERO_BYPASS_EN -> out_product=0, no mul_start pulse; without -> mul_start pulse, result from multiplier model.
REQ-037 Held out_ready=0 for 10 cycles in OUT -> out_product/out_err unchanged, no FIFO pop, no mul_rst.

Source files
------------

// File: rtl/mul_job_sequencer_pkg.sv
// mul_job_sequencer_pkg
//   Shared definitions for the multiply job sequencer: the sequencer FSM
//   state encoding and the default operand width / queue depth.
//   Optional feature macro used by the top: MUL_SEQ_ZERO_BYPASS_EN.
package mul_job_sequencer_pkg;

    localparam int DEF_W     = 16;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MRST  = 3'd1,
        S_START = 3'd2,
        S_LDA   = 3'd3,
        S_LDB   = 3'd4,
        S_RUN   = 3'd5,
        S_OUT   = 3'd6
    } state_e;

endpackage

// File: rtl/mul_pair_fifo.sv
// mul_pair_fifo
//   Small synchronous FIFO holding packed operand pairs for the sequencer.
//   Ports:
//     clk, rst      clock, synchronous active-high reset (empties the FIFO)
//     push, din     write request and data; ignored while full (even if a
//                   pop happens in the same cycle)
//     pop, dout     read request and head-of-queue data (dout is valid
//                   whenever empty is low)
//     full, empty   occupancy flags
module mul_pair_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          push_ok, pop_ok;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_q[AW-1:0]] = din;
            wr_d = wr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mul_job_sequencer.sv
// mul_job_sequencer
//   Queues operand pairs and drives an external shift/add multiplier
//   (separate controller + datapath) one job at a time, returning results
//   strictly in input order with a watchdog on the multiplier's done flag.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     in_valid/in_ready         operand-pair input handshake
//     in_a, in_b                multiplicand, multiplier
//     mul_rst, mul_start        pulses to the multiplier (mul_rst also held
//                               high while rst is high)
//     mul_data                  shared operand bus: a, a, b, then 0
//     mul_done, mul_product     multiplier completion (sticky) and product
//     out_valid/out_ready       result handshake
//     out_product, out_err      result; out_err=1 marks a watchdog abort
//     dbg_state                 current FSM state
//   Handshakes: a transfer happens on a rising clk edge where valid and
//   ready are both high; valid holds its payload stable until accepted.
//   Optional macro MUL_SEQ_ZERO_BYPASS_EN: a head pair with a zero operand
//   is retired directly as product 0 without running the multiplier.
module mul_job_sequencer
    import mul_job_sequencer_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int TMO   = 2**W + 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         mul_rst,
    output logic         mul_start,
    output logic [W-1:0] mul_data,
    input  logic         mul_done,
    input  logic [W-1:0] mul_product,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_product,
    output logic         out_err,
    output state_e       dbg_state
);

    localparam int CW = $clog2(TMO + 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   prod_q, prod_d;
    logic           err_q, err_d;

    logic [2*W-1:0] fifo_dout;
    logic           fifo_full, fifo_empty, fifo_pop;
    logic [W-1:0]   head_a, head_b;
    logic           zero_head;

    assign in_ready = !fifo_full;
    assign head_a   = fifo_dout[2*W-1:W];
    assign head_b   = fifo_dout[W-1:0];

`ifdef MUL_SEQ_ZERO_BYPASS_EN
    assign zero_head = !fifo_empty && ((head_a == '0) || (head_b == '0));
`else
    assign zero_head = 1'b0;
`endif

    mul_pair_fifo #(
        .DW    (2*W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .din   ({in_a, in_b}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (zero_head) begin
                    // Zero operand: result is known, skip the multiplier.
                    fifo_pop = 1'b1;
                    prod_d   = '0;
                    err_d    = 1'b0;
                    state_d  = S_OUT;
                end else if (!fifo_empty) begin
                    state_d = S_MRST;
                end
            end
            S_MRST:  state_d = S_START;
            S_START: state_d = S_LDA;
            S_LDA:   state_d = S_LDB;
            S_LDB: begin
                // Both operands have been presented; retire the pair.
                fifo_pop = 1'b1;
                cnt_d    = '0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (mul_done) begin
                    prod_d  = mul_product;
                    err_d   = 1'b0;
                    state_d = S_OUT;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    // TMO cycles spent in RUN without completion.
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (!fifo_empty && !zero_head) state_d = S_MRST;
                    else                           state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
        end
    end

    // Multiplier-side outputs decode straight from the state register so
    // they are glitch-free single-cycle pulses.
    always_comb begin
        mul_data = '0;
        case (state_q)
            S_START, S_LDA: mul_data = head_a;
            S_LDB:          mul_data = head_b;
            default:        mul_data = '0;
        endcase
    end

    assign mul_rst     = rst || (state_q == S_MRST);
    assign mul_start   = (state_q == S_START);
    assign out_valid   = (state_q == S_OUT);
    assign out_product = prod_q;
    assign out_err     = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mul_job_sequencer.sv
module tb_mul_job_sequencer;
    import mul_job_sequencer_pkg::*;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int TMO   = 20;
    localparam int DLY   = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         mul_rst, mul_start;
    logic [W-1:0] mul_data;
    logic         mul_done;
    logic [W-1:0] mul_product;
    logic         out_valid, out_ready;
    logic [W-1:0] out_product;
    logic         out_err;
    state_e       dbg_state;

    int tests_run;
    int tests_failed;

    logic [W-1:0] exp_q[$];

    mul_job_sequencer #(.W(W), .DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_rst     (mul_rst),
        .mul_start   (mul_start),
        .mul_data    (mul_data),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_err     (out_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- multiplier model ----------------
    // Loads a the cycle after mul_start, b the cycle after that, then
    // raises a sticky done DLY cycles into RUN unless model_hang is set.
    logic         model_hang;
    logic [1:0]   m_phase;
    logic [W-1:0] m_a, m_b;
    int           m_cnt;

    always @(posedge clk) begin
        if (mul_rst) begin
            mul_done    <= 1'b0;
            mul_product <= '0;
            m_phase     <= 2'd0;
            m_cnt       <= 0;
        end else begin
            case (m_phase)
                2'd0: if (mul_start) m_phase <= 2'd1;
                2'd1: begin m_a <= mul_data; m_phase <= 2'd2; end
                2'd2: begin m_b <= mul_data; m_phase <= 2'd3; m_cnt <= 0; end
                default: begin
                    if (!model_hang) begin
                        if (m_cnt == DLY - 1) begin
                            mul_done    <= 1'b1;
                            mul_product <= m_a * m_b;
                            m_phase     <= 2'd0;
                        end else begin
                            m_cnt <= m_cnt + 1;
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- observation monitor ----------------
    int           start_cnt, mrst_cnt, ldb_cnt, run_cyc, ov_cnt;
    logic [W-1:0] d_start, d_lda, d_ldb;

    always @(negedge clk) begin
        if (!rst) begin
            if (mul_start) start_cnt++;
            if (mul_rst)   mrst_cnt++;
            if (out_valid) ov_cnt++;
            case (dbg_state)
                S_START: d_start = mul_data;
                S_LDA:   d_lda   = mul_data;
                S_LDB:   begin d_ldb = mul_data; ldb_cnt++; run_cyc = 0; end
                S_RUN:   run_cyc++;
                default: ;
            endcase
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [W-1:0] ep,
                              input logic ee, output int lat);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_prod"}, {16'd0, out_product}, {16'd0, ep});
        chk({tag, "_err"}, {31'd0, out_err}, {31'd0, ee});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    logic [W-1:0] pa [5];
    logic [W-1:0] pb [5];
    logic [W-1:0] pe [5];
    int           lat;
    int           idx;
    logic         hs;
    int           snap_ldb, snap_mrst;

    initial begin
        tests_run = 0; tests_failed = 0;
        start_cnt = 0; mrst_cnt = 0; ldb_cnt = 0; run_cyc = 0; ov_cnt = 0;
        model_hang = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

        pa[0] = 16'd3;   pb[0] = 16'd4;   pe[0] = 16'd12;
        pa[1] = 16'd7;   pb[1] = 16'd6;   pe[1] = 16'd42;
        pa[2] = 16'd100; pb[2] = 16'd200; pe[2] = 16'd20000;
        pa[3] = 16'd255; pb[3] = 16'd255; pe[3] = 16'd65025;
        pa[4] = 16'd300; pb[4] = 16'd300; pe[4] = 16'd24464; // 90000 mod 2^16

        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mul_rst", {31'd0, mul_rst}, 32'd1);
        chk("rst_mul_start", {31'd0, mul_start}, 32'd0);
        chk("rst_mul_data", {16'd0, mul_data}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_product", {16'd0, out_product}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        chk("rst_mul_rst_low", {31'd0, mul_rst}, 32'd0);

        // Single job 5 x 3
        start_cnt = 0; mrst_cnt = 0;
        push(16'd5, 16'd3);
        get_result("single", 16'd15, 1'b0, lat);
        chk("single_latency", lat, 32'd10);
        chk("single_start_cnt", start_cnt, 32'd1);
        chk("single_mrst_cnt", mrst_cnt, 32'd1);
        chk("single_data_start", {16'd0, d_start}, 32'd5);
        chk("single_data_lda", {16'd0, d_lda}, 32'd5);
        chk("single_data_ldb", {16'd0, d_ldb}, 32'd3);
        chk("single_idle_data", {16'd0, mul_data}, 32'd0);

        // Five pairs back-to-back with out_ready held low
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            if (idx < 5) begin
                in_a = pa[idx]; in_b = pb[idx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            hs = in_valid && in_ready;
            @(negedge clk);
            if (hs) begin
                exp_q.push_back(pe[idx]);
                idx++;
            end
        end
        in_valid = 1'b0;
        chk("burst_accepted", idx, 32'd5);
        chk("burst_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("burst_out_valid", {31'd0, out_valid}, 32'd1);

        // Hold in OUT for 10 cycles: nothing may move
        snap_ldb = ldb_cnt; snap_mrst = mrst_cnt;
        repeat (10) @(negedge clk);
        chk("hold_prod", {16'd0, out_product}, 32'd12);
        chk("hold_err", {31'd0, out_err}, 32'd0);
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_no_pop", ldb_cnt, snap_ldb);
        chk("hold_no_mrst", mrst_cnt, snap_mrst);

        // Drain in order
        while (exp_q.size() > 0) begin
            get_result("burst", exp_q.pop_front(), 1'b0, lat);
        end
        chk("burst_in_ready_after", {31'd0, in_ready}, 32'd1);

        // Watchdog abort, then a normal job
        model_hang = 1'b1;
        push(16'd9, 16'd9);
        get_result("tmo", 16'd0, 1'b1, lat);
        chk("tmo_run_cycles", run_cyc, TMO);
        model_hang = 1'b0;
        push(16'd6, 16'd7);
        get_result("post_tmo", 16'd42, 1'b0, lat);

        // Reset during RUN with two pairs queued
        push(16'd2, 16'd3);
        push(16'd4, 16'd5);
        push(16'd8, 16'd8);
        idx = 0;
        while (dbg_state != S_RUN && idx < 50) begin
            @(negedge clk);
            idx++;
        end
        chk("midrst_reached_run", {29'd0, dbg_state}, {29'd0, S_RUN});
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ov_cnt = 0;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (20) @(negedge clk);
        chk("midrst_no_output", ov_cnt, 32'd0);
        chk("midrst_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
        push(16'd2, 16'd7);
        get_result("post_rst", 16'd14, 1'b0, lat);

        // Zero operand
        start_cnt = 0;
        push(16'd0, 16'd9);
        get_result("zero", 16'd0, 1'b0, lat);
`ifdef MUL_SEQ_ZERO_BYPASS_EN
        chk("zero_start_cnt", start_cnt, 32'd0);
`else
        chk("zero_start_cnt", start_cnt, 32'd1);
`endif

        // Full-scale operands: product truncated to W bits
        push(16'hFFFF, 16'hFFFF);
        get_result("max", 16'h0001, 1'b0, lat);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
